// File: rtl/iot_defs_pkg.sv
// Shared definitions for the teletype IOT device pair: default device codes,
// IOT operation bit positions and the printer state encoding.
package iot_defs;

    localparam logic [5:0] KBD_DEV_CODE = 6'o03;
    localparam logic [5:0] TP_DEV_CODE  = 6'o04;

    localparam int OP_SKIP_BIT = 0;
    localparam int OP_CLR_BIT  = 1;
    localparam int OP_XFER_BIT = 2;

    typedef enum logic [1:0] {
        TP_IDLE = 2'd0,
        TP_SEND = 2'd1,
        TP_BUSY = 2'd2
    } tp_state_t;

    // Op 000 has a device-specific meaning of its own (flag clear / flag set).
    function automatic logic op_is_zero(input logic [2:0] op);
        return op == 3'b000;
    endfunction

endpackage

// File: rtl/tty_printer_fsm.sv
// Teleprinter handshake and print-time counter: a load in IDLE presents the character
// until tp_ready, then BUSY runs PRINT_DELAY cycles; print_done pulses in the last one.
module tty_printer_fsm
    import iot_defs::*;
#(
    parameter int PRINT_DELAY = 16
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       load,
    input  logic [7:0] load_char,
    input  logic       tp_ready,
    output logic [7:0] tp_char,
    output logic       tp_valid,
    output logic       print_done
);

    tp_state_t  state_q;
    logic [7:0] cnt_q;
    logic [7:0] char_q;
    logic       valid_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= TP_IDLE;
            cnt_q   <= 8'd0;
            char_q  <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                TP_IDLE: begin
                    if (load) begin
                        state_q <= TP_SEND;
                        char_q  <= load_char;
                        valid_q <= 1'b1;
                    end
                end
                TP_SEND: begin
                    // char_q is frozen here so the printer sees a stable character.
                    if (valid_q && tp_ready) begin
                        state_q <= TP_BUSY;
                        valid_q <= 1'b0;
                        cnt_q   <= 8'(PRINT_DELAY);
                    end
                end
                TP_BUSY: begin
                    if (cnt_q == 8'd1) begin
                        state_q <= TP_IDLE;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= TP_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign tp_char    = char_q;
    assign tp_valid   = valid_q;
    assign print_done = (state_q == TP_BUSY) && (cnt_q == 8'd1);

endmodule

// File: rtl/iot_teletype.sv
// Keyboard/teleprinter IOT device: decodes CPU IOTs, responds one cycle later with
// registered iot_done/datain/skip/clr_ac; printer side waits on tp_ready.
module iot_teletype
    import iot_defs::*;
#(
    parameter int         PRINT_DELAY = 16,
    parameter logic [5:0] KBD_DEV     = KBD_DEV_CODE,
    parameter logic [5:0] TP_DEV      = TP_DEV_CODE
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       iot_valid,
    input  logic [5:0] iot_dev,
    input  logic [2:0] iot_op,
    input  logic [7:0] dataout,
    output logic       iot_done,
    output logic [7:0] datain,
    output logic       skip,
    output logic       clr_ac,
    input  logic [7:0] kbd_char,
    input  logic       kbd_strobe,
    output logic [7:0] tp_char,
    output logic       tp_valid,
    input  logic       tp_ready
);

    logic       kbd_sel;
    logic       tp_sel;
    logic       tp_load;
    logic       tp_done;

    logic       iot_done_q, iot_done_d;
    logic [7:0] datain_q,   datain_d;
    logic       skip_q,     skip_d;
    logic       clr_ac_q,   clr_ac_d;
    logic [7:0] kbd_buf_q,  kbd_buf_d;
    logic       kbd_flag_q, kbd_flag_d;
    logic       tp_flag_q,  tp_flag_d;

    assign kbd_sel = iot_valid && (iot_dev == KBD_DEV);
    assign tp_sel  = iot_valid && (iot_dev == TP_DEV) && !kbd_sel;
    assign tp_load = tp_sel && iot_op[OP_XFER_BIT];

    // Skip and datain sample the flags/buffer before this instruction's
    // updates; a same-cycle strobe or print completion overrides any clear.
    always_comb begin
        iot_done_d = kbd_sel || tp_sel;
        datain_d   = 8'd0;
        skip_d     = 1'b0;
        clr_ac_d   = 1'b0;
        kbd_buf_d  = kbd_buf_q;
        kbd_flag_d = kbd_flag_q;
        tp_flag_d  = tp_flag_q;

        if (kbd_sel) begin
            skip_d   = iot_op[OP_SKIP_BIT] && kbd_flag_q;
            clr_ac_d = iot_op[OP_CLR_BIT];
            if (iot_op[OP_XFER_BIT]) begin
                datain_d = kbd_buf_q;
            end
            if (iot_op[OP_CLR_BIT] || op_is_zero(iot_op)) begin
                kbd_flag_d = 1'b0;
            end
        end

        if (kbd_strobe) begin
            kbd_buf_d  = kbd_char;
            kbd_flag_d = 1'b1;
        end

        if (tp_sel) begin
            skip_d = iot_op[OP_SKIP_BIT] && tp_flag_q;
            if (op_is_zero(iot_op)) begin
                tp_flag_d = 1'b1;
            end
            if (iot_op[OP_CLR_BIT]) begin
                tp_flag_d = 1'b0;
            end
        end

        if (tp_done) begin
            tp_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            iot_done_q <= 1'b0;
            datain_q   <= 8'd0;
            skip_q     <= 1'b0;
            clr_ac_q   <= 1'b0;
            kbd_buf_q  <= 8'd0;
            kbd_flag_q <= 1'b0;
            tp_flag_q  <= 1'b0;
        end else begin
            iot_done_q <= iot_done_d;
            datain_q   <= datain_d;
            skip_q     <= skip_d;
            clr_ac_q   <= clr_ac_d;
            kbd_buf_q  <= kbd_buf_d;
            kbd_flag_q <= kbd_flag_d;
            tp_flag_q  <= tp_flag_d;
        end
    end

    assign iot_done = iot_done_q;
    assign datain   = datain_q;
    assign skip     = skip_q;
    assign clr_ac   = clr_ac_q;

    tty_printer_fsm #(
        .PRINT_DELAY(PRINT_DELAY)
    ) u_printer (
        .clock      (clock),
        .resetN     (resetN),
        .load       (tp_load),
        .load_char  (dataout),
        .tp_ready   (tp_ready),
        .tp_char    (tp_char),
        .tp_valid   (tp_valid),
        .print_done (tp_done)
    );

endmodule

// File: tb/tb_iot_teletype.sv
// Scoreboard bench for iot_teletype: directed scenarios plus random IOT traffic
// against a timestamp-based behavioural model of the teletype.
module tb_iot_teletype;

    localparam int         DLY = 16;
    localparam logic [5:0] KDEV = 6'o03;
    localparam logic [5:0] TDEV = 6'o04;

    typedef struct packed {
        logic [7:0] data;
        logic       skip;
        logic       clr;
    } resp_t;

    logic       clock;
    logic       resetN;
    logic       iot_valid;
    logic [5:0] iot_dev;
    logic [2:0] iot_op;
    logic [7:0] dataout;
    logic       iot_done;
    logic [7:0] datain;
    logic       skip;
    logic       clr_ac;
    logic [7:0] kbd_char;
    logic       kbd_strobe;
    logic [7:0] tp_char;
    logic       tp_valid;
    logic       tp_ready;

    iot_teletype #(
        .PRINT_DELAY(DLY),
        .KBD_DEV    (KDEV),
        .TP_DEV     (TDEV)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .iot_valid (iot_valid),
        .iot_dev   (iot_dev),
        .iot_op    (iot_op),
        .dataout   (dataout),
        .iot_done  (iot_done),
        .datain    (datain),
        .skip      (skip),
        .clr_ac    (clr_ac),
        .kbd_char  (kbd_char),
        .kbd_strobe(kbd_strobe),
        .tp_char   (tp_char),
        .tp_valid  (tp_valid),
        .tp_ready  (tp_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit running  = 0;

    resp_t        iot_q[$];
    logic [8:0]   tp_q[$];

    // Reference model: flags, buffers and the printer as "idle / waiting for
    // tp_ready / printing until edge N".
    logic       m_kflag, m_tflag;
    logic [7:0] m_kbuf, m_pchar;
    int         m_pr;        // 0 idle, 1 waiting for acceptance, 2 printing
    int         m_done_at;
    int         cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_note(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %0h expected no event", name, act);
    endtask

    task automatic model_reset();
        m_kflag = 0; m_tflag = 0; m_kbuf = 0; m_pchar = 0;
        m_pr = 0; m_done_at = 0;
    endtask

    // Drive one cycle of inputs at the negedge and record what the DUT must show
    // after the following posedge.
    task automatic step(input logic v, input logic [5:0] dev, input logic [2:0] op,
                        input logic [7:0] dout, input logic ks, input logic [7:0] kc,
                        input logic rdy);
        logic       is_k, is_t;
        logic       kflag_n, tflag_n;
        logic [7:0] kbuf_n;
        int         pr_n;
        resp_t      r;
        iot_valid = v; iot_dev = dev; iot_op = op; dataout = dout;
        kbd_strobe = ks; kbd_char = kc; tp_ready = rdy;

        is_k = v && (dev == KDEV);
        is_t = v && (dev == TDEV);
        kflag_n = m_kflag; kbuf_n = m_kbuf; tflag_n = m_tflag; pr_n = m_pr;

        if (is_k) begin
            r.skip = op[0] && m_kflag;
            r.clr  = op[1];
            r.data = op[2] ? m_kbuf : 8'h00;
            if (op[1] || op == 3'b000) kflag_n = 0;
            iot_q.push_back(r);
        end
        if (ks) begin
            kbuf_n = kc;
            kflag_n = 1;
        end
        if (is_t) begin
            r.skip = op[0] && m_tflag;
            r.clr  = 0;
            r.data = 8'h00;
            if (op == 3'b000) tflag_n = 1;
            if (op[1]) tflag_n = 0;
            iot_q.push_back(r);
        end
        if (m_pr == 2 && cyc == m_done_at) begin
            pr_n = 0;
            tflag_n = 1;
        end
        if (m_pr == 1 && rdy) begin
            pr_n = 2;
            m_done_at = cyc + DLY;
        end
        if (m_pr == 0 && is_t && op[2]) begin
            pr_n = 1;
            m_pchar = dout;
        end
        m_kflag = kflag_n; m_kbuf = kbuf_n; m_tflag = tflag_n; m_pr = pr_n;
        tp_q.push_back({pr_n == 1, m_pchar});
        cyc++;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            step(0, 6'o00, 3'b000, 8'h00, 0, 8'h00, rdy);
        end
    endtask

    task automatic iot(input logic [5:0] dev, input logic [2:0] op, input logic [7:0] dout,
                       input logic rdy);
        @(negedge clock);
        step(1, dev, op, dout, 0, 8'h00, rdy);
    endtask

    // Assert reset shortly after issuing an instruction, so that IOT is dropped.
    task automatic reset_pulse(input logic v, input logic [5:0] dev, input logic [2:0] op);
        @(negedge clock);
        step(v, dev, op, 8'h77, 0, 8'h00, 0);
        #2 resetN = 0;
        #1 chk("reset_outputs", 32'({iot_done, datain, skip, clr_ac, tp_valid, tp_char}), 32'h0);
        iot_q.delete();
        tp_q.delete();
        model_reset();
        @(negedge clock);
        @(negedge clock);
        resetN = 1;
        step(0, 6'o00, 3'b000, 8'h00, 0, 8'h00, 0);
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin
        resp_t      e;
        logic [8:0] t;
        forever begin
            @(posedge clock);
            #2;
            if (resetN && running) begin
                if (tp_q.size() == 0) begin
                    fail_note("tp_underflow", 32'({tp_valid, tp_char}));
                end else begin
                    t = tp_q.pop_front();
                    chk("tp_out", 32'({tp_valid, tp_char}), 32'(t));
                end
                if (iot_done) begin
                    if (iot_q.size() == 0) begin
                        fail_note("unexpected_iot_done", 32'({datain, skip, clr_ac}));
                    end else begin
                        e = iot_q.pop_front();
                        chk("iot_resp", 32'({datain, skip, clr_ac}), 32'({e.data, e.skip, e.clr}));
                    end
                end else begin
                    chk("idle_resp_zero", 32'({datain, skip, clr_ac}), 32'h0);
                end
            end
        end
    end

    initial begin
        logic [5:0] dev;
        resetN = 0;
        iot_valid = 0; iot_dev = 0; iot_op = 0; dataout = 0;
        kbd_strobe = 0; kbd_char = 0; tp_ready = 0;
        model_reset();
        #1 chk("reset_state", 32'({iot_done, datain, skip, clr_ac, tp_valid, tp_char}), 32'h0);
        @(negedge clock);
        @(negedge clock);
        resetN = 1;
        running = 1;
        step(0, 6'o00, 3'b000, 8'h00, 0, 8'h00, 0);

        // Keyboard: strobe, KSF, KRB, KSF again.
        @(negedge clock);
        step(0, 6'o00, 3'b000, 8'h00, 1, 8'h41, 1);
        iot(KDEV, 3'd1, 8'h00, 1);
        iot(KDEV, 3'd6, 8'h00, 1);
        iot(KDEV, 3'd1, 8'h00, 1);

        // Teleprinter: TLS 5A with ready high, then poll TSF.
        iot(TDEV, 3'd6, 8'h5A, 1);
        for (int i = 0; i < DLY + 3; i++) iot(TDEV, 3'd1, 8'h00, 1);
        iot(TDEV, 3'd2, 8'h00, 1);

        // Stalled printer: second load ignored, character held.
        iot(TDEV, 3'd6, 8'h5A, 0);
        idle(2, 0);
        iot(TDEV, 3'd6, 8'h33, 0);
        idle(7, 0);
        idle(DLY + 3, 1);

        // Strobe coinciding with KCC, then KRS-with-skip and KRB.
        @(negedge clock);
        step(1, KDEV, 3'd2, 8'h00, 1, 8'h42, 1);
        iot(KDEV, 3'd5, 8'h00, 1);
        iot(KDEV, 3'd6, 8'h00, 1);
        iot(KDEV, 3'd1, 8'h00, 1);

        // Completion coinciding with a TCF clear; set wins.
        iot(TDEV, 3'd6, 8'h21, 1);
        idle(DLY, 1);
        iot(TDEV, 3'd2, 8'h00, 1);
        iot(TDEV, 3'd1, 8'h00, 1);

        // Foreign device, then reset in the middle of a print.
        iot(6'o05, 3'd7, 8'hFF, 1);
        iot(TDEV, 3'd6, 8'h66, 1);
        idle(5, 1);
        reset_pulse(1, TDEV, 3'd1);
        iot(TDEV, 3'd1, 8'h00, 1);
        idle(DLY + 4, 1);
        iot(TDEV, 3'd1, 8'h00, 1);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_pulse($urandom_range(0, 1) == 1, TDEV, 3'($urandom_range(0, 7)));
            end else begin
                case ($urandom_range(0, 3))
                    0: dev = KDEV;
                    1: dev = TDEV;
                    2: dev = 6'o05;
                    default: dev = 6'($urandom_range(0, 63));
                endcase
                @(negedge clock);
                step($urandom_range(0, 9) < 4, dev, 3'($urandom_range(0, 7)),
                     8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0,
                     8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
            end
        end

        idle(3, 1);
        @(posedge clock);
        #3;
        chk("iot_queue_drained", 32'(iot_q.size()), 32'h0);
        chk("tp_queue_drained", 32'(tp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
